// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / branch / memory-wait stall and flush controller
// Freezes the pipeline on slow data memory, bubbles on load-use, flushes on taken branches.
module hazard_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_addr_i,
  input  logic [4:0]       id_rs2_addr_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       ex_rd_addr_i,
  input  logic             ex_mem_rden_i,
  input  logic             ex_br_taken_i,
  input  logic             mem_req_valid_i,
  input  logic             mem_rsp_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_flush_o,
  output logic             mem_fault_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_FAULT} state_t;

  state_t          state, state_nxt;
  logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
  logic            memwait, loaduse;
  logic            freeze, br_flush, lu_stall;

  assign memwait = mem_req_valid_i & ~mem_rsp_ready_i;
  assign loaduse = ex_mem_rden_i & (ex_rd_addr_i != 5'd0) &
                   ((id_rs1_used_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                    (id_rs2_used_i & (id_rs2_addr_i == ex_rd_addr_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // wait_cnt numbers the current MEM_WAIT cycle; the fault fires after MEM_TIMEOUT of them.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (memwait) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!memwait) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_W'(MEM_TIMEOUT)) begin
          state_nxt    = MEM_FAULT;
          wait_cnt_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      MEM_FAULT: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // A held EX stage defers the branch flush to the release cycle.
  always_comb begin
    freeze   = 1'b0;
    br_flush = 1'b0;
    lu_stall = 1'b0;
    if (!rst_i) begin
      freeze   = (state == MEM_FAULT) | memwait;
      br_flush = ~freeze & ex_br_taken_i;
      lu_stall = ~freeze & ~ex_br_taken_i & loaduse;
    end
    pc_stall_o     = freeze | lu_stall;
    if_id_stall_o  = freeze | lu_stall;
    if_id_flush_o  = br_flush;
    id_ex_stall_o  = freeze;
    id_ex_flush_o  = br_flush | lu_stall;
    ex_mem_stall_o = freeze;
    mem_wb_flush_o = freeze;
    mem_fault_o    = ~rst_i & (state == MEM_FAULT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_stall_o)
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (br_flush)
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0010_1000;
  localparam logic [7:0] FRZ  = 8'b1101_0110;
  localparam logic [7:0] FLT  = 8'b1101_0111;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i, ex_mem_rden_i, ex_br_taken_i;
  logic        mem_req_valid_i, mem_rsp_ready_i;
  logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o;
  logic        id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_fault_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;
  logic [7:0]  outs;

  int errors = 0;
  int checks = 0;

  hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_addr_i(ex_rd_addr_i), .ex_mem_rden_i(ex_mem_rden_i),
    .ex_br_taken_i(ex_br_taken_i),
    .mem_req_valid_i(mem_req_valid_i), .mem_rsp_ready_i(mem_rsp_ready_i),
    .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o),
    .if_id_flush_o(if_id_flush_o), .id_ex_stall_o(id_ex_stall_o),
    .id_ex_flush_o(id_ex_flush_o), .ex_mem_stall_o(ex_mem_stall_o),
    .mem_wb_flush_o(mem_wb_flush_o), .mem_fault_o(mem_fault_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  assign outs = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_stall_o,
                 id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o, mem_fault_o};

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    id_rs1_addr_i = 5'd0; id_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0; ex_mem_rden_i = 1'b0;
    ex_br_taken_i = 1'b0; mem_req_valid_i = 1'b0; mem_rsp_ready_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    #2;
    chk("reset_outs", 32'(outs), 32'(NONE));
    chk("reset_stall_cnt", stall_cnt_o, 32'd0);
    chk("reset_flush_cnt", flush_cnt_o, 32'd0);
    step();
    rst_i = 1'b0;
    step();

    // load-use: lw x5 in EX, add x?,x5 in ID
    ex_mem_rden_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5; id_rs1_used_i = 1'b1;
    #2 chk("loaduse", 32'(outs), 32'(LU));
    step();
    idle();
    #2 chk("loaduse_after", 32'(outs), 32'(NONE));
    chk("loaduse_stall_cnt", stall_cnt_o, 32'd1);

    // rd = x0 never stalls
    ex_mem_rden_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs1_addr_i = 5'd0; id_rs1_used_i = 1'b1;
    #2 chk("rd_x0", 32'(outs), 32'(NONE));
    step();
    // matching rs2 that is not read
    idle();
    ex_mem_rden_i = 1'b1; ex_rd_addr_i = 5'd7; id_rs2_addr_i = 5'd7; id_rs2_used_i = 1'b0;
    id_rs1_addr_i = 5'd3; id_rs1_used_i = 1'b1;
    #2 chk("rs2_unused", 32'(outs), 32'(NONE));
    step();
    chk("no_stall_cnt", stall_cnt_o, 32'd1);

    // branch beats load-use
    idle();
    ex_mem_rden_i = 1'b1; ex_rd_addr_i = 5'd9; id_rs2_addr_i = 5'd9; id_rs2_used_i = 1'b1;
    ex_br_taken_i = 1'b1;
    #2 chk("branch_over_lu", 32'(outs), 32'(BR));
    step();
    chk("branch_flush_cnt", flush_cnt_o, 32'd1);
    chk("branch_stall_cnt", stall_cnt_o, 32'd1);

    // memory wait 3 cycles; a taken branch arrives while frozen
    idle();
    mem_req_valid_i = 1'b1;
    #2 chk("memwait_c1", 32'(outs), 32'(FRZ));
    step();
    ex_br_taken_i = 1'b1;
    #2 chk("memwait_c2_br", 32'(outs), 32'(FRZ));
    step();
    #2 chk("memwait_c3_br", 32'(outs), 32'(FRZ));
    step();
    mem_rsp_ready_i = 1'b1;
    #2 chk("memwait_release_br", 32'(outs), 32'(BR));
    step();
    idle();
    #2 chk("memwait_back_run", 32'(outs), 32'(NONE));
    chk("memwait_stall_cnt", stall_cnt_o, 32'd4);
    chk("memwait_flush_cnt", flush_cnt_o, 32'd2);
    step();

    // timeout: entry cycle, four MEM_WAIT cycles, then one fault cycle
    mem_req_valid_i = 1'b1;
    #2 chk("timeout_entry", 32'(outs), 32'(FRZ));
    step();
    for (int i = 1; i <= 4; i++) begin
      #2 chk($sformatf("timeout_wait%0d", i), 32'(outs), 32'(FRZ));
      chk($sformatf("timeout_wcnt%0d", i), 32'(dut.wait_cnt), 32'(i));
      step();
    end
    #2 chk("timeout_fault", 32'(outs), 32'(FLT));
    step();
    idle();
    #2 chk("timeout_back_run", 32'(outs), 32'(NONE));
    chk("timeout_stall_cnt", stall_cnt_o, 32'd10);
    step();

    // reset on the second MEM_WAIT cycle
    mem_req_valid_i = 1'b1;
    step();
    step();
    #2 chk("rstwait_frozen", 32'(outs), 32'(FRZ));
    rst_i = 1'b1;
    #1;
    chk("rstwait_outs", 32'(outs), 32'(NONE));
    chk("rstwait_stall_cnt", stall_cnt_o, 32'd0);
    chk("rstwait_flush_cnt", flush_cnt_o, 32'd0);
    chk("rstwait_wcnt", 32'(dut.wait_cnt), 32'd0);
    step();
    rst_i = 1'b0;
    #2 chk("rstwait_fresh", 32'(outs), 32'(FRZ));
    step();
    chk("rstwait_fresh_wcnt", 32'(dut.wait_cnt), 32'd1);
    chk("rstwait_fresh_stall_cnt", stall_cnt_o, 32'd1);
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
